// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel and the
// decode-facing instruction handshake. "master" is the fetch stage.
interface instruction_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output if_valid, if_instr, if_pc,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  if_valid, if_instr, if_pc,
    output if_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage around the PC register: issues in-order imem reads, buffers the
// returned words in a small circular queue, and drops reads made stale by redirects.
module instruction_fetch #(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pc_current,
  output logic [31:0]         pc_next,
  output logic                pc_write_en,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  instruction_fetch_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      pc_d    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      instr_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [PW-1:0]    fill_q, fill_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    drop_q, drop_d;

  logic [31:0]      pc_aligned;
  logic [31:0]      redirect_aligned;
  logic [CW-1:0]    filled_cnt;
  logic [CW-1:0]    unfilled;
  logic [CW:0]      occupancy;
  logic [CW:0]      drop_sum;
  logic             req_valid;
  logic             deliver_valid;
  logic             issue;
  logic             pop;
  logic             rsp_fill;
  logic             rsp_drop;
  logic             unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Filled bits are only ever set on allocated entries, so allocated-but-empty
  // entries are simply count minus the filled population.
  always_comb begin
    filled_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      filled_cnt = filled_cnt + CW'(filled_q[i]);
    end
  end

  assign unfilled         = count_q - filled_cnt;
  assign pc_aligned       = {pc_current[31:2], 2'b00};
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign occupancy        = {1'b0, count_q} + {1'b0, drop_q};
  assign drop_sum         = {1'b0, drop_q} + {1'b0, unfilled};

  assign req_valid     = !rst && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
  assign issue         = req_valid && bus.imem_req_ready;
  assign deliver_valid = !rst && !redirect_valid && (count_q != '0) && filled_q[head_q];
  assign pop           = deliver_valid && bus.if_ready;
  assign rsp_drop      = bus.imem_rsp_valid && (drop_q != '0);
  assign rsp_fill      = bus.imem_rsp_valid && (drop_q == '0) && (unfilled != '0);

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_aligned;
  assign bus.if_valid       = deliver_valid;
  assign bus.if_instr       = instr_q[head_q];
  assign bus.if_pc          = pc_q[head_q];

  assign pc_write_en = !rst && (redirect_valid || issue);
  assign pc_next     = redirect_valid ? redirect_aligned
                     : (issue ? pc_aligned + 32'd4 : pc_current);

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    filled_d = filled_q;
    head_d   = head_q;
    tail_d   = tail_q;
    fill_d   = fill_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (redirect_valid) begin
      head_d   = '0;
      tail_d   = '0;
      fill_d   = '0;
      filled_d = '0;
      count_d  = '0;
      // A response landing this cycle retires one of the outstanding reads.
      if (bus.imem_rsp_valid && (drop_sum != '0)) begin
        drop_d = CW'(drop_sum - (CW+1)'(1));
      end else begin
        drop_d = CW'(drop_sum);
      end
    end else begin
      if (issue) begin
        pc_d[tail_q]     = pc_aligned;
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + PW'(1);
      end
      if (rsp_fill) begin
        instr_d[fill_q]  = bus.imem_rsp_data;
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + PW'(1);
      end
      if (rsp_drop) begin
        drop_d = drop_q - CW'(1);
      end
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PW'(1);
      end
      count_d = count_q + CW'(issue) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      filled_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      fill_q   <= fill_d;
      filled_q <= filled_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_q    <= pc_d;
    instr_q <= instr_d;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a randomized run, all
// checked every cycle against a program-order / epoch-based reference model.
module tb_instruction_fetch;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_current;
  logic [31:0] pc_next;
  logic        pc_write_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  instruction_fetch_if bus();

  instruction_fetch #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_current     (pc_current),
    .pc_next        (pc_next),
    .pc_write_en    (pc_write_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;
  bit mem_const = 1'b0;
  logic [31:0] pc_reg = 32'h0;

  // Reference model: issued-but-undelivered PCs of the live epoch, how many of
  // them already have data, and the memory's in-flight reads tagged by epoch.
  logic [31:0] exp_pc[$];
  int arrived = 0;
  int epoch = 0;
  int infl_due[$];
  int infl_ep[$];
  logic [31:0] infl_addr[$];

  logic        s_req_valid, s_pc_we, s_if_valid, s_rsp_valid;
  logic [31:0] s_req_addr, s_pc_next, s_if_pc, s_if_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] h;
    h = addr * 32'h9E3779B1;
    return mem_const ? 32'h13 : (h ^ 32'h0000_0013);
  endfunction

  task automatic run_cycle(input bit r, input bit redir, input logic [31:0] rpc,
                           input bit rdy, input bit ifr, input bit rsp_en);
    int stale;
    bit rv, e_req, e_we, e_ifv, issue, pop;
    logic [31:0] e_next, al;
    rv = rsp_en && (infl_due.size() > 0) && (infl_due.size() > 0 ? infl_due[0] <= cyc : 1'b0);
    rst = r;
    redirect_valid = redir;
    redirect_pc = rpc;
    bus.imem_req_ready = rdy;
    bus.if_ready = ifr;
    bus.imem_rsp_valid = rv;
    if (rv) bus.imem_rsp_data = mem_word(infl_addr[0]);
    else    bus.imem_rsp_data = $urandom;
    pc_current = pc_reg;

    stale = 0;
    foreach (infl_ep[i]) if (infl_ep[i] != epoch) stale++;
    al     = {pc_reg[31:2], 2'b00};
    e_req  = !r && !redir && ((exp_pc.size() + stale) < DEPTH);
    issue  = e_req && rdy;
    e_ifv  = !r && !redir && (arrived > 0);
    pop    = e_ifv && ifr;
    e_we   = !r && (redir || issue);
    e_next = redir ? {rpc[31:2], 2'b00} : (issue ? al + 32'd4 : pc_reg);

    #4;
    s_req_valid = bus.imem_req_valid;
    s_req_addr  = bus.imem_req_addr;
    s_pc_we     = pc_write_en;
    s_pc_next   = pc_next;
    s_if_valid  = bus.if_valid;
    s_if_pc     = bus.if_pc;
    s_if_instr  = bus.if_instr;
    s_rsp_valid = rv;

    checks++;
    if (s_req_valid !== e_req) begin
      failures++;
      $display("FAIL req_valid cyc=%0d: got %b expected %b", cyc, s_req_valid, e_req);
    end
    if (e_req) begin
      checks++;
      if (s_req_addr !== al) begin
        failures++;
        $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, s_req_addr, al);
      end
    end
    checks++;
    if (s_pc_we !== e_we) begin
      failures++;
      $display("FAIL pc_write_en cyc=%0d: got %b expected %b", cyc, s_pc_we, e_we);
    end
    if (!r) begin
      checks++;
      if (s_pc_next !== e_next) begin
        failures++;
        $display("FAIL pc_next cyc=%0d: got %h expected %h", cyc, s_pc_next, e_next);
      end
    end
    checks++;
    if (s_if_valid !== e_ifv) begin
      failures++;
      $display("FAIL if_valid cyc=%0d: got %b expected %b", cyc, s_if_valid, e_ifv);
    end
    if (e_ifv) begin
      checks++;
      if (s_if_pc !== exp_pc[0]) begin
        failures++;
        $display("FAIL if_pc cyc=%0d: got %h expected %h", cyc, s_if_pc, exp_pc[0]);
      end
      checks++;
      if (s_if_instr !== mem_word(exp_pc[0])) begin
        failures++;
        $display("FAIL if_instr cyc=%0d: got %h expected %h", cyc, s_if_instr, mem_word(exp_pc[0]));
      end
    end

    if (r) begin
      exp_pc.delete();
      arrived = 0;
      epoch++;
      infl_due.delete();
      infl_ep.delete();
      infl_addr.delete();
    end else begin
      if (rv) begin
        if (infl_ep[0] == epoch) arrived++;
        void'(infl_due.pop_front());
        void'(infl_ep.pop_front());
        void'(infl_addr.pop_front());
      end
      if (redir) begin
        exp_pc.delete();
        arrived = 0;
        epoch++;
      end else begin
        if (issue) begin
          exp_pc.push_back(al);
          infl_due.push_back(cyc + lat);
          infl_ep.push_back(epoch);
          infl_addr.push_back(al);
        end
        if (pop) begin
          void'(exp_pc.pop_front());
          arrived--;
        end
      end
      if (e_we) pc_reg = e_next;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    run_cycle(1, 0, 0, 1, 1, 1);
    run_cycle(1, 0, 0, 1, 1, 1);
    pc_reg = start_pc;
  endtask

  task automatic test_reset;
    pc_reg = 32'h0;
    mem_const = 1'b0;
    lat = 1;
    run_cycle(1, 0, 0, 1, 1, 1);
    run_cycle(1, 1, 32'h40, 1, 1, 1);
    checks++;
    if (s_req_valid !== 1'b0 || s_pc_we !== 1'b0 || s_if_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got req=%b we=%b ifv=%b expected 0 0 0", s_req_valid, s_pc_we, s_if_valid);
    end
    run_cycle(0, 0, 0, 0, 1, 1);
    checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0 || s_if_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: got req=%b addr=%h ifv=%b expected 1 00000000 0", s_req_valid, s_req_addr, s_if_valid);
    end
  endtask

  task automatic test_streaming;
    logic [31:0] got[$];
    mem_const = 1'b1;
    lat = 1;
    do_reset(32'h0);
    for (int c = 0; c < 12; c++) begin
      run_cycle(0, 0, 0, 1, 1, 1);
      if (c < 2) begin
        checks++;
        if (s_req_valid !== 1'b1 || s_req_addr !== 32'(c * 4)) begin
          failures++;
          $display("FAIL stream_req c=%0d: got v=%b addr=%h expected 1 %h", c, s_req_valid, s_req_addr, 32'(c * 4));
        end
      end
      if (c == 2) begin
        checks++;
        if (s_if_valid !== 1'b1 || s_if_pc !== 32'h0 || s_if_instr !== 32'h13) begin
          failures++;
          $display("FAIL stream_first c=2: got v=%b pc=%h instr=%h expected 1 0 13", s_if_valid, s_if_pc, s_if_instr);
        end
      end
      if (s_if_valid === 1'b1) got.push_back(s_if_pc);
    end
    checks++;
    if (got.size() < 3 || got[0] !== 32'h0 || got[1] !== 32'h4 || got[2] !== 32'h8) begin
      failures++;
      $display("FAIL stream_order: got %0d deliveries expected in-order 0,4,8", got.size());
    end
    mem_const = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [31:0] got[$];
    logic [31:0] first_req;
    bit seen_req;
    lat = 1;
    do_reset(32'h0);
    for (int c = 0; c < 6; c++) begin
      run_cycle(0, 0, 0, 1, 0, 1);
      if (c == 3) begin
        checks++;
        if (s_req_valid !== 1'b0 || s_pc_we !== 1'b0) begin
          failures++;
          $display("FAIL bp_full: got req=%b we=%b expected 0 0", s_req_valid, s_pc_we);
        end
      end
    end
    seen_req = 1'b0;
    first_req = 32'hDEAD_BEEF;
    for (int c = 0; c < 6; c++) begin
      run_cycle(0, 0, 0, 1, 1, 1);
      if (s_if_valid === 1'b1) got.push_back(s_if_pc);
      if (!seen_req && s_req_valid === 1'b1) begin
        seen_req = 1'b1;
        first_req = s_req_addr;
      end
    end
    checks++;
    if (got.size() < 2 || got[0] !== 32'h0 || got[1] !== 32'h4) begin
      failures++;
      $display("FAIL bp_drain: got %0d deliveries expected 0 then 4", got.size());
    end
    checks++;
    if (first_req !== 32'h8) begin
      failures++;
      $display("FAIL bp_resume: got %h expected 00000008", first_req);
    end
  endtask

  task automatic test_redirect_inflight;
    logic [31:0] first_pc;
    bit seen;
    lat = 3;
    do_reset(32'h0);
    run_cycle(0, 0, 0, 1, 1, 1);
    run_cycle(0, 0, 0, 1, 1, 1);
    run_cycle(0, 1, 32'h103, 1, 1, 1);
    checks++;
    if (s_pc_next !== 32'h100 || s_pc_we !== 1'b1 || s_if_valid !== 1'b0) begin
      failures++;
      $display("FAIL redir_pc: got next=%h we=%b ifv=%b expected 00000100 1 0", s_pc_next, s_pc_we, s_if_valid);
    end
    seen = 1'b0;
    first_pc = 32'hDEAD_BEEF;
    for (int c = 0; c < 20; c++) begin
      run_cycle(0, 0, 0, 1, 1, 1);
      if (!seen && s_if_valid === 1'b1) begin
        seen = 1'b1;
        first_pc = s_if_pc;
      end
    end
    checks++;
    if (first_pc !== 32'h100) begin
      failures++;
      $display("FAIL redir_first: got %h expected 00000100", first_pc);
    end
  endtask

  task automatic test_redirect_coincident;
    logic [31:0] first_pc;
    bit seen;
    lat = 2;
    do_reset(32'h0);
    run_cycle(0, 0, 0, 1, 0, 1);
    run_cycle(0, 0, 0, 1, 0, 1);
    run_cycle(0, 0, 0, 1, 0, 1);
    // head 0x0 holds data, 0x4 is unfilled and its response lands now
    run_cycle(0, 1, 32'h200, 1, 1, 1);
    checks++;
    if (s_if_valid !== 1'b0 || s_rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL coinc_nodeliver: got ifv=%b rsp=%b expected 0 1", s_if_valid, s_rsp_valid);
    end
    run_cycle(0, 0, 0, 1, 1, 1);
    checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h200) begin
      failures++;
      $display("FAIL coinc_reissue: got v=%b addr=%h expected 1 00000200", s_req_valid, s_req_addr);
    end
    seen = 1'b0;
    first_pc = 32'hDEAD_BEEF;
    for (int c = 0; c < 10; c++) begin
      run_cycle(0, 0, 0, 1, 1, 1);
      if (!seen && s_if_valid === 1'b1) begin
        seen = 1'b1;
        first_pc = s_if_pc;
      end
    end
    checks++;
    if (first_pc !== 32'h200) begin
      failures++;
      $display("FAIL coinc_first: got %h expected 00000200", first_pc);
    end
  endtask

  task automatic test_mem_stall;
    lat = 1;
    do_reset(32'h40);
    for (int c = 0; c < 5; c++) begin
      run_cycle(0, 0, 0, 0, 1, 1);
      checks++;
      if (s_req_valid !== 1'b1 || s_req_addr !== 32'h40 || s_pc_we !== 1'b0) begin
        failures++;
        $display("FAIL stall c=%0d: got v=%b addr=%h we=%b expected 1 00000040 0", c, s_req_valid, s_req_addr, s_pc_we);
      end
    end
    run_cycle(0, 0, 0, 1, 1, 1);
    checks++;
    if (s_pc_we !== 1'b1 || s_pc_next !== 32'h44) begin
      failures++;
      $display("FAIL stall_accept: got we=%b next=%h expected 1 00000044", s_pc_we, s_pc_next);
    end
  endtask

  task automatic test_wrap_reset;
    lat = 3;
    do_reset(32'hFFFF_FFFC);
    run_cycle(0, 0, 0, 1, 1, 1);
    checks++;
    if (s_req_addr !== 32'hFFFF_FFFC || s_pc_we !== 1'b1 || s_pc_next !== 32'h0) begin
      failures++;
      $display("FAIL wrap: got addr=%h we=%b next=%h expected fffffffc 1 00000000", s_req_addr, s_pc_we, s_pc_next);
    end
    run_cycle(0, 0, 0, 1, 1, 1);
    run_cycle(1, 0, 0, 1, 1, 1);
    run_cycle(0, 0, 0, 1, 1, 1);
    checks++;
    if (s_if_valid !== 1'b0 || s_req_valid !== 1'b1) begin
      failures++;
      $display("FAIL midreset: got ifv=%b req=%b expected 0 1", s_if_valid, s_req_valid);
    end
    for (int c = 0; c < 10; c++) run_cycle(0, 0, 0, 1, 1, 1);
  endtask

  task automatic test_random;
    int delivered;
    bit r, rd;
    delivered = 0;
    lat = 1;
    do_reset($urandom);
    for (int chunk = 0; chunk < 15; chunk++) begin
      lat = 1 + int'($urandom_range(0, 3));
      for (int c = 0; c < 200; c++) begin
        r  = ($urandom_range(0, 399) == 0);
        rd = !r && ($urandom_range(0, 15) == 0);
        run_cycle(r, rd, $urandom, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0));
        if (s_if_valid === 1'b1 && !r) delivered++;
      end
    end
    checks++;
    if (delivered < 200) begin
      failures++;
      $display("FAIL random_activity: got %0d deliveries expected at least 200", delivered);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    pc_current = 32'h0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = 32'h0;
    bus.if_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_coincident();
    test_mem_stall();
    test_wrap_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
